// File: rtl/decade_clock_gen.sv
// Cascaded decade clock-enable generator: per-channel one-cycle ticks plus 50% squares.
// Optional square decode is built only when CLOCKS_SQUARE_EN is defined; otherwise square_o is 0.
module decade_clock_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BASE_HZ = 10,
  parameter int DECADE  = 10,
  parameter int NUM_CH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] square_o
);

  localparam int PRESCALE = CLK_HZ / BASE_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW       = (DECADE > 1) ? $clog2(DECADE) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(PRESCALE / 2);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECADE - 1);
  localparam logic [DW-1:0] DEC_HALF = DW'(DECADE / 2);

  logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
  logic              base;
  logic [NUM_CH-1:0] at_last;
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] carry_q, carry_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  assign base       = en & (pre_cnt_q == PRE_LAST);
  assign at_last[0] = 1'b1;
  assign carry[0]   = base;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
    end
  end

  // The wrap event is parked in carry_q while en is low so a paused tick is
  // neither lost nor duplicated; it emerges on the next enabled edge.
  always_comb begin
    carry_d = carry_q;
    tick_d  = '0;
    if (clr) begin
      carry_d = '0;
    end else if (en) begin
      carry_d = carry;
      tick_d  = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      carry_q   <= '0;
      tick_q    <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      carry_q   <= carry_d;
      tick_q    <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef CLOCKS_SQUARE_EN
  assign square_o[0] = (pre_cnt_q < PRE_HALF);
`else
  assign square_o[0] = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 1; gi < NUM_CH; gi++) begin : g_stage
      logic [DW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (carry[gi-1]) begin
          cnt_d = (cnt_q == DEC_LAST) ? '0 : cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign at_last[gi] = (cnt_q == DEC_LAST);
      // Prefix AND of terminal counts avoids a self-referencing carry chain.
      assign carry[gi]   = base & (&at_last[gi:0]);

`ifdef CLOCKS_SQUARE_EN
      assign square_o[gi] = (cnt_q < DEC_HALF);
`else
      assign square_o[gi] = 1'b0;
`endif
    end
  endgenerate

`ifndef CLOCKS_SQUARE_EN
  logic unused_half;
  assign unused_half = ^{PRE_HALF, DEC_HALF};
`endif

endmodule

// File: tb/tb_decade_clock_gen.sv
// Scoreboard bench for decade_clock_gen (PRESCALE=10, DECADE=4, NUM_CH=3).
// Expected values come from counting enabled edges since reset/clear.
module tb_decade_clock_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] tick_o;
  logic [2:0] square_o;

  always #5 clk = ~clk;

  decade_clock_gen #(
    .CLK_HZ (20),
    .BASE_HZ(2),
    .DECADE (4),
    .NUM_CH (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .tick_o  (tick_o),
    .square_o(square_o)
  );

`ifdef CLOCKS_SQUARE_EN
  localparam bit SQ_BUILD = 1'b1;
`else
  localparam bit SQ_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] tick;
    logic [2:0] sq;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   ev      = 0;   // enabled edges since reset/clear
  bit   last_en = 1'b0;
  int   cyc     = 0;

  function automatic logic [2:0] exp_square(input int n);
    logic [2:0] s;
    s[0] = ((n % 10) < 5);
    s[1] = (((n / 10) % 4) < 2);
    s[2] = (((n / 40) % 4) < 2);
    return SQ_BUILD ? s : 3'b000;
  endfunction

  function automatic logic [2:0] exp_tick(input int n, input bit was_en);
    logic [2:0] t;
    t = 3'b000;
    if (was_en && n > 1) begin
      t[0] = ((n % 10) == 1);
      t[1] = ((n % 40) == 1);
      t[2] = ((n % 160) == 1);
    end
    return t;
  endfunction

  task automatic step(input logic en_i, input logic clr_i);
    exp_t x;
    en  = en_i;
    clr = clr_i;
    @(posedge clk);
    #1;
    cyc++;
    if (rst || clr_i) begin
      ev      = 0;
      last_en = 1'b0;
    end else if (en_i) begin
      ev++;
      last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    x.tick = exp_tick(ev, last_en);
    x.sq   = exp_square(ev);
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      total++;
      if (tick_o !== x.tick) begin
        bad++;
        $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick_o, x.tick);
      end
      total++;
      if (square_o !== x.sq) begin
        bad++;
        $display("FAIL square cyc=%0d got=%b want=%b", cyc, square_o, x.sq);
      end
      if (x.tick != 3'b000)
        $display("tick cyc=%0d tick=%b square=%b", cyc, tick_o, square_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset held, then free run: ticks every 10/40/160 enabled edges.
    repeat (3) step(1'b0, 1'b0);
    rst = 1'b0;
    repeat (400) step(1'b1, 1'b0);

    // Pause for 7 cycles once the prescaler reaches 4.
    while ((ev % 10) != 4) step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0);

    // Clear exactly when every counter sits on its terminal value.
    while (!((ev % 10) == 9 && ((ev / 10) % 4) == 3 && ((ev / 40) % 4) == 3))
      step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (200) step(1'b1, 1'b0);

    // Asynchronous reset mid-cycle with cnt[1] == 2.
    while (!(((ev / 10) % 4) == 2 && (ev % 10) == 5)) step(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (tick_o !== 3'b000) begin
      bad++;
      $display("FAIL async_rst_tick got=%b want=%b", tick_o, 3'b000);
    end
    total++;
    if (square_o !== exp_square(0)) begin
      bad++;
      $display("FAIL async_rst_square got=%b want=%b", square_o, exp_square(0));
    end
    repeat (2) step(1'b0, 1'b0);
    rst = 1'b0;
    repeat (400) step(1'b1, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
